// File: rtl/iomem_pkg.sv
// Shared definitions for the iomem peripheral bus: initiator FSM states,
// responder base addresses (decoded on addr[31:24]) and the default error read value.
package iomem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [7:0]  BASE_LED      = 8'h03;
  localparam logic [7:0]  BASE_NEOPIXEL = 8'h04;
  localparam logic [7:0]  BASE_LCD      = 8'h05;

  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hFFFF_FFFF;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/iomem_initiator_if.sv
// Command, response and iomem bus signals of the initiator, grouped as one bundle.
// "master" is the initiator's view; "slave" is the view of whatever surrounds it.
interface iomem_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    input  rsp_ready, iomem_ready, iomem_rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    output rsp_ready, iomem_ready, iomem_rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata
  );
endinterface

// File: rtl/iomem_watchdog.sv
// Request watchdog: 16-bit clear/enable counter; expired flags the last
// cycle a request may stay outstanding.
module iomem_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // The count lags the cycles already spent waiting by one, so compare against
  // TIMEOUT_CYCLES-1 to abort exactly after TIMEOUT_CYCLES cycles of valid.
  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/iomem_initiator.sv
// Single-outstanding iomem bus master: accepts one command, runs it on the
// peripheral bus with a timeout, and returns read data or an error response.
module iomem_initiator
  import iomem_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
  input  logic               clk,
  input  logic               resetn,
  iomem_initiator_if.master  bus,
  output logic               busy
);

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        iomem_valid_q, iomem_valid_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        busy_q, busy_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        accept;
  logic        expired;

  assign accept = cmd_ready_q && bus.cmd_valid;

  iomem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (accept),
    .en      (state_q == REQ),
    .expired (expired)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = word_align(bus.cmd_addr);
          wdata_d = bus.cmd_wdata;
          wstrb_d = bus.cmd_write ? bus.cmd_wstrb : 4'b0000;
          state_d = REQ;
        end
      end
      REQ: begin
        // A ready on the timeout edge still completes the transfer normally.
        if (bus.iomem_ready) begin
          rdata_d   = (wstrb_q == 4'b0000) ? bus.iomem_rdata : 32'h0;
          rsp_err_d = 1'b0;
          state_d   = RESP;
        end else if (expired) begin
          rdata_d   = ERR_RDATA;
          rsp_err_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_valid_q && bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs follow the next state so they change on the same edge.
    cmd_ready_d   = (state_d == IDLE);
    iomem_valid_d = (state_d == REQ);
    rsp_valid_d   = (state_d == RESP);
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      iomem_valid_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      rsp_err_q     <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      iomem_valid_q <= iomem_valid_d;
      rsp_valid_q   <= rsp_valid_d;
      busy_q        <= busy_d;
      rsp_err_q     <= rsp_err_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rdata_q       <= rdata_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.iomem_valid = iomem_valid_q;
  assign bus.iomem_addr  = addr_q;
  assign bus.iomem_wdata = wdata_q;
  assign bus.iomem_wstrb = wstrb_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_iomem_initiator.sv
// Directed bench for iomem_initiator with a programmable wait-state responder
// and TIMEOUT_CYCLES = 8.
module tb_iomem_initiator;

  logic clk = 1'b0;
  logic resetn;
  logic busy;

  iomem_initiator_if bus_i ();

  iomem_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_i),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int vtot  = 0;
  int v0;
  int acc_cyc;
  int acc_prev;

  // Responder: after resp_wait cycles of valid, ready pulses for one cycle.
  logic        resp_en = 1'b0;
  int          resp_wait = 1;
  logic [31:0] resp_data = 32'h0;
  logic        rr = 1'b0;
  logic        stray_ready = 1'b0;
  logic [31:0] rdr = 32'h0;
  int          wcnt = 0;

  assign bus_i.iomem_ready = rr | stray_ready;
  assign bus_i.iomem_rdata = rdr;

  always @(negedge clk) begin
    if (!resp_en || !bus_i.iomem_valid) begin
      rr = 1'b0; wcnt = 0;
    end else if (rr) begin
      rr = 1'b0; wcnt = 0;
    end else if (wcnt == resp_wait) begin
      rr = 1'b1; rdr = resp_data;
    end else begin
      wcnt++;
    end
  end

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    vtot <= vtot + int'(bus_i.iomem_valid);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Offer a command from a negedge; returns at the negedge after the accept edge.
  task automatic issue(input string tag, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, input logic keep);
    int n = 0;
    bus_i.cmd_valid = 1'b1;
    bus_i.cmd_write = wr;
    bus_i.cmd_addr  = a;
    bus_i.cmd_wdata = d;
    bus_i.cmd_wstrb = s;
    while (!bus_i.cmd_ready && n < 20) begin
      @(negedge clk); n++;
    end
    chk({tag, "_cmd_ready"}, 32'(bus_i.cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!keep) bus_i.cmd_valid = 1'b0;
    v0      = vtot;
    acc_cyc = cyc;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!bus_i.rsp_valid && n < 40) begin
      @(negedge clk); n++;
    end
    chk({tag, "_rsp_valid_seen"}, 32'(bus_i.rsp_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    resetn          = 1'b0;
    bus_i.cmd_valid = 1'b0;
    bus_i.cmd_write = 1'b0;
    bus_i.cmd_addr  = '0;
    bus_i.cmd_wdata = '0;
    bus_i.cmd_wstrb = '0;
    bus_i.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready",   32'(bus_i.cmd_ready),   32'd0);
    chk("rst_iomem_valid", 32'(bus_i.iomem_valid), 32'd0);
    chk("rst_rsp_valid",   32'(bus_i.rsp_valid),   32'd0);
    chk("rst_busy",        32'(busy),              32'd0);
    chk("rst_rsp_rdata",   bus_i.rsp_rdata,        32'h0);
    chk("rst_rsp_err",     32'(bus_i.rsp_err),     32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready",   32'(bus_i.cmd_ready),   32'd1);

    // Write with unaligned address, one wait cycle
    resp_en = 1'b1; resp_wait = 1; resp_data = 32'hCAFE_0001;
    bus_i.rsp_ready = 1'b1;
    issue("wr", 1'b1, 32'h0300_0002, 32'h1122_3344, 4'b0001, 1'b0);
    chk("wr_iomem_valid", 32'(bus_i.iomem_valid), 32'd1);
    chk("wr_iomem_addr",  bus_i.iomem_addr,       32'h0300_0000);
    chk("wr_iomem_wstrb", 32'(bus_i.iomem_wstrb), 32'd1);
    chk("wr_iomem_wdata", bus_i.iomem_wdata,      32'h1122_3344);
    chk("wr_cmd_ready",   32'(bus_i.cmd_ready),   32'd0);
    chk("wr_busy",        32'(busy),              32'd1);
    @(negedge clk);
    chk("wr_rsp_early",   32'(bus_i.rsp_valid),   32'd0);
    @(negedge clk);
    chk("wr_rsp_valid",   32'(bus_i.rsp_valid),   32'd1);
    chk("wr_valid_drop",  32'(bus_i.iomem_valid), 32'd0);
    chk("wr_valid_cyc",   32'(vtot - v0),         32'd2);
    chk("wr_rsp_rdata",   bus_i.rsp_rdata,        32'h0);
    chk("wr_rsp_err",     32'(bus_i.rsp_err),     32'd0);
    @(negedge clk);
    chk("wr_rsp_consumed", 32'(bus_i.rsp_valid),  32'd0);
    chk("wr_cmd_ready_back", 32'(bus_i.cmd_ready), 32'd1);

    // Read with three wait cycles
    resp_wait = 3; resp_data = 32'hA5A5_5A5A;
    issue("rd", 1'b0, 32'h0300_0000, 32'h0, 4'b1111, 1'b0);
    chk("rd_iomem_wstrb", 32'(bus_i.iomem_wstrb), 32'd0);
    wait_rsp("rd");
    chk("rd_valid_cyc",   32'(vtot - v0),         32'd4);
    chk("rd_rsp_rdata",   bus_i.rsp_rdata,        32'hA5A5_5A5A);
    chk("rd_rsp_err",     32'(bus_i.rsp_err),     32'd0);
    @(negedge clk);

    // Write with zero strobes behaves as a read
    resp_wait = 1; resp_data = 32'h0BAD_F00D;
    issue("wz", 1'b1, 32'h0500_0008, 32'h0000_0055, 4'b0000, 1'b0);
    chk("wz_iomem_wstrb", 32'(bus_i.iomem_wstrb), 32'd0);
    wait_rsp("wz");
    chk("wz_rsp_rdata",   bus_i.rsp_rdata,        32'h0BAD_F00D);
    @(negedge clk);

    // Timeout: responder silent
    resp_en = 1'b0;
    issue("to", 1'b0, 32'h0400_0010, 32'h0, 4'b0000, 1'b0);
    wait_rsp("to");
    chk("to_valid_cyc",   32'(vtot - v0),         32'd8);
    chk("to_iomem_valid", 32'(bus_i.iomem_valid), 32'd0);
    chk("to_rsp_err",     32'(bus_i.rsp_err),     32'd1);
    chk("to_rsp_rdata",   bus_i.rsp_rdata,        32'hFFFF_FFFF);
    @(negedge clk);

    // Ready on the timeout edge wins
    resp_en = 1'b1; resp_wait = 7; resp_data = 32'h1357_9BDF;
    issue("tie", 1'b0, 32'h0400_0014, 32'h0, 4'b0000, 1'b0);
    wait_rsp("tie");
    chk("tie_valid_cyc",  32'(vtot - v0),         32'd8);
    chk("tie_rsp_err",    32'(bus_i.rsp_err),     32'd0);
    chk("tie_rsp_rdata",  bus_i.rsp_rdata,        32'h1357_9BDF);
    @(negedge clk);

    // Response backpressure
    resp_wait = 1; resp_data = 32'h1234_5678;
    bus_i.rsp_ready = 1'b0;
    issue("bp", 1'b0, 32'h0500_0000, 32'h0, 4'b0000, 1'b0);
    wait_rsp("bp");
    bus_i.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(bus_i.rsp_valid), 32'd1);
      chk("bp_rsp_rdata", bus_i.rsp_rdata,      32'h1234_5678);
      chk("bp_cmd_ready", 32'(bus_i.cmd_ready), 32'd0);
    end
    bus_i.cmd_valid = 1'b0;
    bus_i.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_consumed",    32'(bus_i.rsp_valid),   32'd0);
    chk("bp_cmd_ready_back", 32'(bus_i.cmd_ready), 32'd1);
    chk("bp_rdata_kept",  bus_i.rsp_rdata,        32'h1234_5678);

    // Stray ready while idle is ignored
    resp_en = 1'b0;
    rdr = 32'hDEAD_BEEF;
    stray_ready = 1'b1;
    @(negedge clk);
    stray_ready = 1'b0;
    @(negedge clk);
    chk("stray_busy",      32'(busy),             32'd0);
    chk("stray_rsp_valid", 32'(bus_i.rsp_valid),  32'd0);
    chk("stray_rdata",     bus_i.rsp_rdata,       32'h1234_5678);

    // Reset while the request is outstanding
    issue("mr", 1'b0, 32'h0300_0004, 32'h0, 4'b0000, 1'b0);
    @(negedge clk);
    chk("mr_valid_before", 32'(bus_i.iomem_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mr_iomem_valid",  32'(bus_i.iomem_valid), 32'd0);
    chk("mr_busy",         32'(busy),              32'd0);
    chk("mr_rsp_valid",    32'(bus_i.rsp_valid),   32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("mr_cmd_ready",    32'(bus_i.cmd_ready),   32'd1);
    chk("mr_no_rsp",       32'(bus_i.rsp_valid),   32'd0);

    // Back-to-back writes with cmd_valid and rsp_ready held high
    resp_en = 1'b1; resp_wait = 1;
    acc_prev = 0;
    for (int i = 0; i < 4; i++) begin
      issue("b2b", 1'b1, 32'h0300_0000 + 32'(4 * i), 32'hB0B0_0000 + 32'(i), 4'b1111, 1'b1);
      chk("b2b_wdata", bus_i.iomem_wdata, 32'hB0B0_0000 + 32'(i));
      chk("b2b_addr",  bus_i.iomem_addr,  32'h0300_0000 + 32'(4 * i));
      if (i > 0) chk("b2b_spacing", 32'(acc_cyc - acc_prev), 32'd4);
      acc_prev = acc_cyc;
      @(negedge clk);
      @(negedge clk);
      chk("b2b_rsp_valid", 32'(bus_i.rsp_valid), 32'd1);
      chk("b2b_rsp_rdata", bus_i.rsp_rdata,      32'h0);
      chk("b2b_rsp_err",   32'(bus_i.rsp_err),   32'd0);
    end
    bus_i.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
